// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use stall, redirect flush, MEM-wait freeze.
// Latency: pipe enables/flushes are combinational (0 cycles); state, counters and err_o are registered (1 cycle).
// Backpressure: dmem_req_i & ~dmem_ready_i freezes every pipeline register until the access completes.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-low reset
//   id_rs1_i/id_rs2_i/id_use_rs*_i source operands of the instruction in ID
//   ex_memread_i, ex_rd_i          load-in-EX indication and its destination
//   ex_redirect_i                  taken branch/jal/jalr resolved in EX
//   dmem_req_i, dmem_ready_i       MEM-stage data memory handshake
//   *_write_o, *_flush_o           pipeline register enables and bubble strobes
//   state_o                        decision applied last cycle (0 RUN, 1 STALL, 2 FLUSH, 3 WAIT)
//   stall_cnt_o, flush_cnt_o       saturating statistics
//   err_o                          sticky MEM-wait watchdog error
module pipe_hazard_ctrl #(
   parameter int CNT_W      = 16,
   parameter int WAIT_LIMIT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_redirect_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             exmem_write_o,
   output logic             memwb_write_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] WAIT_LIM_C = CNT_W'(WAIT_LIMIT);

   logic hold, lu, rd;
   logic apply_rd, apply_lu;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;

   // Hazard terms, evaluated every cycle.
   always_comb begin
      hold = dmem_req_i & ~dmem_ready_i;
      lu   = ex_memread_i & (ex_rd_i != 5'd0) &
             ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
              (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
      rd   = ex_redirect_i;
      // A frozen pipe applies nothing; a redirect makes the ID instruction
      // wrong-path, so it wins over a simultaneous load-use.
      apply_rd = ~hold & rd;
      apply_lu = ~hold & ~rd & lu;
   end

   // Pipe controls depend only on the current hazard terms, so they keep
   // working while reset is asserted.
   always_comb begin
      pc_write_o    = ~hold & ~apply_lu;
      ifid_write_o  = ~hold & ~apply_lu;
      ifid_flush_o  = apply_rd;
      idex_flush_o  = apply_rd | apply_lu;
      exmem_write_o = ~hold;
      memwb_write_o = ~hold;
   end

   always_comb begin
      if (hold)    state_d = ST_WAIT;
      else if (rd) state_d = ST_FLUSH;
      else if (lu) state_d = ST_STALL;
      else         state_d = ST_RUN;

      stall_cnt_d = stall_cnt_q;
      if (apply_lu && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;

      flush_cnt_d = flush_cnt_q;
      if (apply_rd && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;

      // Wait counter saturates so a very long wait can never wrap back
      // below the limit; err_o latches the cycle the limit is reached.
      wait_cnt_d = '0;
      if (hold) wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

      err_d = err_q | (hold & (wait_cnt_d == WAIT_LIM_C));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   assign err_o       = err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It detects load-use hazards in ID, squashes wrong-path instructions on EX-resolved redirects (branch/jal/jalr), and freezes the whole pipeline while a data-memory access in MEM waits on a ready handshake. It drives write-enables and flush strobes to PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps stall/flush statistics plus a memory-wait watchdog.

Parameters:
CNT_W, 16, width of the saturating stall and flush counters
WAIT_LIMIT, 64, consecutive MEM-wait cycles before err_o is raised (1..2^CNT_W-1)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous active-low reset
id_rs1_i  input  5  rs1 field of the instruction in ID
id_rs2_i  input  5  rs2 field of the instruction in ID
id_use_rs1_i  input  1  ID instruction reads rs1
id_use_rs2_i  input  1  ID instruction reads rs2
ex_memread_i  input  1  instruction in EX is a load
ex_rd_i  input  5  destination register of the instruction in EX
ex_redirect_i  input  1  EX resolved a taken branch, jal or jalr this cycle
dmem_req_i  input  1  MEM stage is issuing a load/store this cycle
dmem_ready_i  input  1  data memory completes the access this cycle
pc_write_o  output  1  PC register update enable
ifid_write_o  output  1  IF/ID register update enable
ifid_flush_o  output  1  load a NOP into IF/ID
idex_flush_o  output  1  load a bubble (all controls 0) into ID/EX
exmem_write_o  output  1  EX/MEM register update enable
memwb_write_o  output  1  MEM/WB register update enable
state_o  output  2  registered FSM state: 0 RUN, 1 STALL, 2 FLUSH, 3 WAIT
stall_cnt_o  output  CNT_W  load-use stall cycles, saturating
flush_cnt_o  output  CNT_W  redirect flush events, saturating
err_o  output  1  sticky watchdog error

Behaviour:
- Hazard terms, combinational, all evaluated every cycle:
  - hold = dmem_req_i & ~dmem_ready_i
  - lu = ex_memread_i & (ex_rd_i != 0) & ((id_use_rs1_i & id_rs1_i == ex_rd_i) | (id_use_rs2_i & id_rs2_i == ex_rd_i))
  - rd = ex_redirect_i
- Priority is hold > rd > lu. Outputs are a combinational function of these terms only:
  - hold: every *_write_o = 0, all flushes = 0. The entire pipe freezes; EX contents persist, so rd/lu re-evaluate once the pipe releases.
  - rd (no hold): all writes = 1, ifid_flush_o = 1, idex_flush_o = 1. The redirect overrides any simultaneous lu, because the ID instruction is wrong-path.
  - lu (no hold, no rd): pc_write_o = 0, ifid_write_o = 0, idex_flush_o = 1, exmem/memwb writes = 1. The stall lasts exactly 1 cycle, since the load advances to MEM.
  - none: all writes = 1, all flushes = 0.
- FSM state register tracks the decision taken in the previous cycle:
  - Next state is WAIT if hold, else FLUSH if rd, else STALL if lu, else RUN.
  - Any state may go to any state.
  - Reset state is RUN.
- Counters:
  - stall_cnt_o increments on a cycle where lu is the applied decision.
  - flush_cnt_o increments on a cycle where rd is the applied decision.
  - Both saturate at all-ones and never wrap.
- Watchdog:
  - An internal wait counter increments each hold cycle and clears on any non-hold cycle.
  - err_o is set on the cycle the counter reaches WAIT_LIMIT.
  - Once set, err_o stays 1 until reset and does not affect the pipe outputs.
- Reset (rst_i = 0, asynchronous):
  - state_o = 0, both counters = 0, wait counter = 0, err_o = 0.
  - While reset is asserted, the combinational outputs still follow the rules above.
  - Reset asserted mid-WAIT clears the watchdog immediately; no err_o is raised.
- A cycle with dmem_req_i = 1 and dmem_ready_i = 1 is not a hold. It completes in the same cycle.

Test Plan:
- Load-use on rs2: ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, id_use_rs2_i=1 -> for one cycle pc_write_o=0, ifid_write_o=0, idex_flush_o=1. Next cycle state_o=1, stall_cnt_o=1. Same stimulus with ex_rd_i=0, or id_use_rs2_i=0 -> no stall.
- Redirect colliding with load-use: ex_redirect_i=1 and lu true together -> ifid_flush_o=1, idex_flush_o=1, pc_write_o=1. flush_cnt_o=1, stall_cnt_o=0.
- MEM wait with pending redirect: dmem_req_i=1 and dmem_ready_i=0 for 3 cycles while ex_redirect_i=1 -> all writes 0 and no flushes for 3 cycles, state_o=3. On the ready cycle, flushes assert once and flush_cnt_o=1.
- Watchdog: WAIT_LIMIT=4, hold for 4 cycles -> err_o rises after the 4th edge. Release the hold -> err_o stays 1. Reset -> err_o=0.
- Saturation: CNT_W=2, 5 separate load-use events -> stall_cnt_o=3.
- Async reset during WAIT: drop rst_i mid-clock -> state_o=0, counters=0 without a clock edge. Release and hold 3 more cycles with WAIT_LIMIT=4 -> err_o stays 0.
